// File: rtl/neuromorphic_asic_bridge_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | neuromorphic_asic_bridge_if                                            |
// | AXI4-Lite bus bundle between host interconnect and the ASIC bridge.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface neuromorphic_asic_bridge_if;
  logic [8:0]  S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [8:0]  S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface
`default_nettype wire

// File: rtl/neuromorphic_asic_bridge.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | neuromorphic_asic_bridge                                               |
// | AXI4-Lite register bridge driving digit bus, LEDs and XADC mux; the    |
// | PWM/slow-clock LED generator is built only when PWM_BLK_EN is defined. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module neuromorphic_asic_bridge (
  input  logic                             S_AXI_ACLK,
  input  logic                             S_AXI_ARESET,
  neuromorphic_asic_bridge_if.slave        s_axi,
  output logic [15:0]                      digit,
  output logic [7:0]                       leds,
  input  logic                             VP,
  input  logic                             VN,
  output logic [3:0]                       XADC_MUXADDR
);
  localparam int NUM_REGS       = 11;
  localparam int IDX_NET_IN     = 1;
  localparam int IDX_LED        = 2;
  localparam int IDX_DBG        = 3;
  localparam int IDX_PWM_DIV    = 8;
  localparam int IDX_PWM_DUTY   = 9;
  localparam int IDX_XADC       = 10;
  localparam logic [3:0] IDX_STATUS = 4'd11;

  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];
  logic        awready_q, awready_d;
  logic        bvalid_q, bvalid_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  vp_sync_q, vp_sync_d;
  logic [1:0]  vn_sync_q, vn_sync_d;
  logic        wr_fire, rd_fire;
  logic [3:0]  wr_idx, rd_idx;
  logic [31:0] rd_word;
  logic        unused_inputs;

  assign unused_inputs = ^{s_axi.S_AXI_WSTRB, s_axi.S_AXI_AWADDR[8:6], s_axi.S_AXI_AWADDR[1:0],
                           s_axi.S_AXI_ARADDR[8:6], s_axi.S_AXI_ARADDR[1:0]};

  always_comb begin
    wr_idx  = s_axi.S_AXI_AWADDR[5:2];
    rd_idx  = s_axi.S_AXI_ARADDR[5:2];
    wr_fire = awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
    rd_fire = arready_q & s_axi.S_AXI_ARVALID;

    // Ready is a one-cycle pulse; the ~ready term stops a second accept of the same beat.
    awready_d = s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~bvalid_q & ~awready_q;
    arready_d = s_axi.S_AXI_ARVALID & ~rvalid_q & ~arready_q;
    bvalid_d  = wr_fire | (bvalid_q & ~s_axi.S_AXI_BREADY);
    rvalid_d  = rd_fire | (rvalid_q & ~s_axi.S_AXI_RREADY);

    rd_word = 32'h0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == 4'(i)) rd_word = regs_q[i];
    end
    if (rd_idx == IDX_STATUS) rd_word = {30'b0, vn_sync_q[1], vp_sync_q[1]};
    rdata_d = rd_fire ? rd_word : rdata_q;

    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = (wr_fire && (wr_idx == 4'(i))) ? s_axi.S_AXI_WDATA : regs_q[i];
    end

    vp_sync_d = {vp_sync_q[0], VP};
    vn_sync_d = {vn_sync_q[0], VN};
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 32'h0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      vp_sync_q <= 2'b00;
      vn_sync_q <= 2'b00;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      vp_sync_q <= vp_sync_d;
      vn_sync_q <= vn_sync_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = awready_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign s_axi.S_AXI_RVALID  = rvalid_q;

  assign digit        = regs_q[IDX_NET_IN][15:0];
  assign XADC_MUXADDR = regs_q[IDX_XADC][3:0];

`ifdef PWM_BLK_EN
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] phase_mask;
  logic [4:0]  div;
  logic        pwm_q, pwm_d;
  logic        slow_clk_q, slow_clk_d;

  always_comb begin
    div        = regs_q[IDX_PWM_DIV][4:0];
    phase_mask = (32'd1 << div) - 32'd1;
    cnt_d      = cnt_q + 32'd1;
    // Compare against the full 32-bit duty so DUTY >= 2^D saturates high.
    pwm_d      = (cnt_q & phase_mask) < regs_q[IDX_PWM_DUTY];
    slow_clk_d = cnt_q[div];
    if (regs_q[IDX_DBG][6])      leds = {8{pwm_q}};
    else if (regs_q[IDX_DBG][3]) leds = {regs_q[IDX_LED][7:1], slow_clk_q};
    else                         leds = regs_q[IDX_LED][7:0];
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      cnt_q      <= 32'h0;
      pwm_q      <= 1'b0;
      slow_clk_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pwm_q      <= pwm_d;
      slow_clk_q <= slow_clk_d;
    end
  end
`else
  assign leds = regs_q[IDX_LED][7:0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_neuromorphic_asic_bridge.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_neuromorphic_asic_bridge                                            |
// | Randomized self-checking bench with an address-map reference model.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_neuromorphic_asic_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vp = 1'b0;
  logic        vn = 1'b0;
  logic [15:0] digit;
  logic [7:0]  leds;
  logic [3:0]  xadc_muxaddr;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] model_regs [11];

  neuromorphic_asic_bridge_if bus ();

  neuromorphic_asic_bridge dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .s_axi        (bus),
    .digit        (digit),
    .leds         (leds),
    .VP           (vp),
    .VN           (vn),
    .XADC_MUXADDR (xadc_muxaddr)
  );

  always #5 clk = ~clk;

  // Byte-address view of the register map.
  function automatic logic [31:0] model_read(input logic [8:0] addr);
    int word = int'(addr[5:2]);
    if (word <= 10) return model_regs[word];
    if (word == 11) return {30'b0, vn, vp};
    return 32'h0;
  endfunction

  task automatic axi_write(input logic [8:0] addr, input logic [31:0] data);
    bit ok = 0;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = 4'($urandom);
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.S_AXI_AWREADY && bus.S_AXI_WREADY) begin ok = 1; break; end
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL write_accept addr=%h: got no AWREADY/WREADY, required within 20 cycles", addr);
    end
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    if (int'(addr[5:2]) <= 10) model_regs[int'(addr[5:2])] = data;
    tests_run++;
    if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00) begin
      tests_failed++;
      $display("FAIL write_resp addr=%h: got bvalid=%b bresp=%b, required 1/00",
               addr, bus.S_AXI_BVALID, bus.S_AXI_BRESP);
    end
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [8:0] addr, input bit hold,
                          output logic [31:0] data, output logic [1:0] resp);
    bit ok = 0;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.S_AXI_ARREADY) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    tests_run++;
    if (!ok || bus.S_AXI_RVALID !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_accept addr=%h: got arready_seen=%0d rvalid=%b, required 1/1",
               addr, ok, bus.S_AXI_RVALID);
    end
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    if (!hold) begin
      bus.S_AXI_RREADY = 1'b1;
      @(posedge clk); #1;
      bus.S_AXI_RREADY = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_ARVALID = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_ARREADY, bus.S_AXI_RVALID} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_handshake: got %b, required 00000",
               {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_ARREADY, bus.S_AXI_RVALID});
    end
    tests_run++;
    if (bus.S_AXI_RDATA !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_rdata: got %h, required 00000000", bus.S_AXI_RDATA);
    end
    tests_run++;
    if ({digit, leds, xadc_muxaddr} !== 28'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got digit=%h leds=%h xadc=%h, required 0", digit, leds, xadc_muxaddr);
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_ARVALID = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_deadbeef();
    logic [31:0] d;
    logic [1:0]  r;
    for (int a = 0; a <= 'h28; a += 4) axi_write(9'(a), 32'hDEAD_BEEF);
    for (int a = 0; a <= 'h28; a += 4) begin
      axi_read(9'(a), 1'b0, d, r);
      tests_run++;
      if (d !== 32'hDEAD_BEEF || r !== 2'b00) begin
        tests_failed++;
        $display("FAIL deadbeef_read addr=%h: got %h resp=%b, required deadbeef/00", a, d, r);
      end
    end
    tests_run++;
    if (digit !== 16'hBEEF || xadc_muxaddr !== 4'hF) begin
      tests_failed++;
      $display("FAIL deadbeef_pins: got digit=%h xadc=%h, required beef/f", digit, xadc_muxaddr);
    end
  endtask

  task automatic test_random_regs();
    logic [31:0] d;
    logic [1:0]  r;
    int          errs = 0;
    for (int i = 0; i < 24; i++) axi_write(9'($urandom_range(0, 15) * 4), $urandom);
    for (int a = 0; a < 64; a += 4) begin
      axi_read(9'(a), 1'b0, d, r);
      tests_run++;
      if (d !== model_read(9'(a)) || r !== 2'b00) begin
        tests_failed++;
        $display("FAIL random_read addr=%h: got %h resp=%b, required %h/00", a, d, r, model_read(9'(a)));
      end
    end
    tests_run++;
    if (digit !== model_regs[1][15:0] || xadc_muxaddr !== model_regs[10][3:0]) errs++;
    if (errs != 0) begin
      tests_failed++;
      $display("FAIL random_pins: got digit=%h xadc=%h, required %h/%h",
               digit, xadc_muxaddr, model_regs[1][15:0], model_regs[10][3:0]);
    end
  endtask

  task automatic test_status();
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(9'h30, 1'b0, d, r);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL unmapped_read 0x30: got %h, required 00000000", d);
    end
    axi_write(9'h2C, $urandom);
    axi_write(9'h3C, $urandom);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin vp = 1'b1; vn = 1'b0; end
      else begin vp = 1'($urandom); vn = 1'($urandom); end
      repeat (3) @(posedge clk);
      #1;
      axi_read(9'h2C, 1'b0, d, r);
      tests_run++;
      if (d !== model_read(9'h2C)) begin
        tests_failed++;
        $display("FAIL status_read vp=%b vn=%b: got %h, required %h", vp, vn, d, model_read(9'h2C));
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] old_v = model_regs[5];
    logic [31:0] new_v = ~old_v ^ $urandom;
    logic [31:0] d;
    logic [1:0]  r;
    bit          ok = 0;
    bus.S_AXI_AWADDR  = 9'h14;
    bus.S_AXI_WDATA   = new_v;
    bus.S_AXI_ARADDR  = 9'h14;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_ARVALID = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.S_AXI_AWREADY) begin ok = 1; break; end
    end
    tests_run++;
    if (!ok || bus.S_AXI_ARREADY !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_cycle_accept: got awready_seen=%0d arready=%b, required 1/1", ok, bus.S_AXI_ARREADY);
    end
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_ARVALID = 1'b0;
    model_regs[5] = new_v;
    tests_run++;
    if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_RDATA !== old_v) begin
      tests_failed++;
      $display("FAIL same_cycle_old: got rvalid=%b bvalid=%b rdata=%h, required 1/1/%h",
               bus.S_AXI_RVALID, bus.S_AXI_BVALID, bus.S_AXI_RDATA, old_v);
    end
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    axi_read(9'h14, 1'b0, d, r);
    tests_run++;
    if (d !== new_v) begin
      tests_failed++;
      $display("FAIL same_cycle_new: got %h, required %h", d, new_v);
    end
  endtask

  task automatic test_led_mode();
    logic [31:0] lv;
    logic [31:0] dv;
    for (int i = 0; i < 4; i++) begin
      lv = $urandom;
`ifdef PWM_BLK_EN
      dv = $urandom & ~32'h48;
`else
      dv = $urandom | 32'h48;
`endif
      axi_write(9'h0C, dv);
      axi_write(9'h08, lv);
      tests_run++;
      if (leds !== lv[7:0]) begin
        tests_failed++;
        $display("FAIL led_mode dbg=%h: got leds=%h, required %h", dv, leds, lv[7:0]);
      end
    end
  endtask

`ifdef PWM_BLK_EN
  task automatic test_slow_clock();
    logic [31:0] lv;
    int          d, half, last, toggles;
    bit          prev, bad_int, bad_up;
    for (int k = 0; k < 3; k++) begin
      d    = (k == 0) ? 2 : $urandom_range(0, 4);
      half = 1 << d;
      lv   = (k == 0) ? 32'h0 : $urandom;
      axi_write(9'h08, lv);
      axi_write(9'h20, 32'(d));
      axi_write(9'h0C, 32'h08);
      repeat (2) @(posedge clk);
      #1;
      prev = leds[0]; last = -1; toggles = 0; bad_int = 0; bad_up = 0;
      for (int c = 0; c < 16 * half; c++) begin
        @(posedge clk); #1;
        if (leds[7:1] !== lv[7:1]) bad_up = 1;
        if (leds[0] !== prev) begin
          if (last >= 0 && (c - last) != half) bad_int = 1;
          last = c; toggles++; prev = leds[0];
        end
      end
      tests_run++;
      if (bad_int || toggles < 15) begin
        tests_failed++;
        $display("FAIL slow_clock div=%0d: got toggles=%0d irregular=%0d, required >=15 every %0d cycles",
                 d, toggles, bad_int, half);
      end
      tests_run++;
      if (bad_up) begin
        tests_failed++;
        $display("FAIL slow_clock_upper div=%0d: got leds[7:1] deviating, required %h", d, lv[7:1]);
      end
    end
  endtask

  task automatic measure_pwm(input int d, input logic [31:0] duty, input string tag);
    int period = 1 << d;
    int n      = (d < 5) ? 32 : 2 * period;
    int highs  = 0;
    int expect_h;
    bit bad    = 0;
    axi_write(9'h24, duty);
    repeat (2) @(posedge clk);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (leds === 8'hFF) highs++;
      else if (leds !== 8'h00) bad = 1;
    end
    expect_h = ((duty >= 32'(period)) ? period : int'(duty)) * (n / period);
    tests_run++;
    if (highs != expect_h || bad) begin
      tests_failed++;
      $display("FAIL %s div=%0d duty=%0d: got %0d of %0d high (bad_level=%0d), required %0d",
               tag, d, duty, highs, n, bad, expect_h);
    end
  endtask

  task automatic test_pwm_fixed();
    axi_write(9'h0C, 32'h4C);
    axi_write(9'h20, 32'd3);
    measure_pwm(3, 32'd3, "pwm_duty3");
    measure_pwm(3, 32'd0, "pwm_duty0");
    measure_pwm(3, 32'd8, "pwm_duty8");
  endtask

  task automatic test_pwm_sweep();
    int period;
    for (int d = 0; d < 8; d++) begin
      period = 1 << d;
      axi_write(9'h20, 32'(d) | ($urandom & 32'hFFFF_FFE0) & 32'h0);
      measure_pwm(d, 32'd0, "pwm_sweep");
      measure_pwm(d, 32'(period), "pwm_sweep");
      measure_pwm(d, 32'(period + $urandom_range(1, 100)), "pwm_sweep_over");
      measure_pwm(d, 32'((d > 0) ? $urandom_range(1, period - 1) : 1), "pwm_sweep");
      measure_pwm(d, 32'($urandom_range(0, period)), "pwm_sweep");
    end
  endtask
`endif

  task automatic test_reset_mid_read();
    logic [31:0] d;
    logic [1:0]  r;
    vp = 1'b0;
    vn = 1'b0;
    axi_read(9'h04, 1'b1, d, r);
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (bus.S_AXI_RVALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_read: got rvalid=%b, required 0", bus.S_AXI_RVALID);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 11; i++) model_regs[i] = 32'h0;
    @(posedge clk); #1;
    for (int a = 0; a < 48; a += 4) begin
      axi_read(9'(a), 1'b0, d, r);
      tests_run++;
      if (d !== model_read(9'(a))) begin
        tests_failed++;
        $display("FAIL post_reset_read addr=%h: got %h, required %h", a, d, model_read(9'(a)));
      end
    end
    tests_run++;
    if ({digit, leds, xadc_muxaddr} !== 28'h0) begin
      tests_failed++;
      $display("FAIL post_reset_pins: got digit=%h leds=%h xadc=%h, required 0", digit, leds, xadc_muxaddr);
    end
  endtask

  initial begin
    bus.S_AXI_AWADDR  = '0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA   = '0;
    bus.S_AXI_WSTRB   = '0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_ARADDR  = '0;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b0;
    for (int i = 0; i < 11; i++) model_regs[i] = 32'h0;
    test_reset();
    test_deadbeef();
    test_random_regs();
    test_status();
    test_same_cycle();
    test_led_mode();
`ifdef PWM_BLK_EN
    test_slow_clock();
    test_pwm_fixed();
    test_pwm_sweep();
`endif
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at 5 ms, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
